// File: rtl/i2c_wb_bridge.sv
// i2c_wb_bridge: turns byte streams from an I2C slave into 16-bit Wishbone
// master cycles. Command byte bit 0 selects read (1) or write (0), followed by
// a 16-bit address and, for writes, 16-bit data. Read data is returned as two
// bytes through the tx_data/tx_dstrb interface.
// Optional feature: define I2C_WB_BRIDGE_TIMEOUT_EN to abort bus cycles that
// are not acknowledged within TIMEOUT clocks (sets the sticky bus_err_o).
// Handshake: rx_dstrb/tx_dstrb are single-cycle qualifiers; a byte is moved
// exactly on the cycle its strobe is high, and tx_dstrb is only raised when
// tx_busy is low and tx_dstrb was low on the previous cycle.
module i2c_wb_bridge #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i2c_cmnd_strb,
   input  logic [7:0]  rx_data,
   input  logic        rx_dstrb,
   output logic [7:0]  tx_data,
   output logic        tx_dstrb,
   input  logic        tx_busy,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [15:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        bus_err_o,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      CMD     = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      BUS     = 3'd5,
      RESP_HI = 3'd6,
      RESP_LO = 3'd7
   } state_t;

   state_t      state, next_state;
   logic        we_q;
   logic [15:0] resp;
   logic        rx_take;
   logic        ld_cmd, ld_adr_hi, ld_adr_lo, ld_dat_hi, ld_dat_lo;
   logic        cyc_set, bus_done, bus_tmo, send_hi, send_lo;
   logic        tmo_hit;

   // A zero timeout would abort every cycle before it could be acknowledged.
   if (TIMEOUT == 16'd0) begin : g_timeout_zero
      $error("i2c_wb_bridge: TIMEOUT must be nonzero");
   end

   assign dbg_state = state;
   // A command strobe outranks a data byte arriving on the same cycle.
   assign rx_take   = rx_dstrb && !i2c_cmnd_strb;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= CMD;
      else       state <= next_state;
   end

   // Next-state decode and per-cycle load/strobe enables.
   always_comb begin
      next_state = state;
      ld_cmd     = 1'b0;
      ld_adr_hi  = 1'b0;
      ld_adr_lo  = 1'b0;
      ld_dat_hi  = 1'b0;
      ld_dat_lo  = 1'b0;
      cyc_set    = 1'b0;
      bus_done   = 1'b0;
      bus_tmo    = 1'b0;
      send_hi    = 1'b0;
      send_lo    = 1'b0;
      case (state)
         CMD: if (rx_take) begin
            ld_cmd     = 1'b1;
            next_state = ADDR_HI;
         end
         ADDR_HI: if (rx_take) begin
            ld_adr_hi  = 1'b1;
            next_state = ADDR_LO;
         end
         ADDR_LO: if (rx_take) begin
            ld_adr_lo  = 1'b1;
            next_state = we_q ? DATA_HI : BUS;
         end
         DATA_HI: if (rx_take) begin
            ld_dat_hi  = 1'b1;
            next_state = DATA_LO;
         end
         DATA_LO: if (rx_take) begin
            ld_dat_lo  = 1'b1;
            next_state = BUS;
         end
         BUS: begin
            if (!wb_cyc_o) begin
               cyc_set = 1'b1;
            end else if (wb_ack_i) begin
               bus_done   = 1'b1;
               next_state = we_q ? CMD : RESP_HI;
            end else if (tmo_hit) begin
               bus_tmo    = 1'b1;
               next_state = we_q ? CMD : RESP_HI;
            end
         end
         RESP_HI: if (!tx_busy && !tx_dstrb && !i2c_cmnd_strb) begin
            send_hi    = 1'b1;
            next_state = RESP_LO;
         end
         RESP_LO: if (!tx_busy && !tx_dstrb && !i2c_cmnd_strb) begin
            send_lo    = 1'b1;
            next_state = CMD;
         end
         default: next_state = CMD;
      endcase
      // The bus cycle is never abandoned by the I2C side.
      if (i2c_cmnd_strb && state != BUS) next_state = CMD;
   end

   // Datapath: command/address/data capture, Wishbone controls, response bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q     <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= 16'h0000;
         wb_dat_o <= 16'h0000;
         resp     <= 16'h0000;
         tx_data  <= 8'h00;
         tx_dstrb <= 1'b0;
      end else begin
         tx_dstrb <= 1'b0;
         if (ld_cmd)    we_q           <= ~rx_data[0];
         if (ld_adr_hi) wb_adr_o[15:8] <= rx_data;
         if (ld_adr_lo) wb_adr_o[7:0]  <= rx_data;
         if (ld_dat_hi) wb_dat_o[15:8] <= rx_data;
         if (ld_dat_lo) wb_dat_o[7:0]  <= rx_data;
         if (cyc_set) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we_q;
         end
         if (bus_done || bus_tmo) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
         end
         if (bus_done && !we_q) resp <= wb_dat_i;
         if (bus_tmo && !we_q)  resp <= 16'hDEAD;
         if (send_hi) begin
            tx_data  <= resp[15:8];
            tx_dstrb <= 1'b1;
         end
         if (send_lo) begin
            tx_data  <= resp[7:0];
            tx_dstrb <= 1'b1;
         end
      end
   end

`ifdef I2C_WB_BRIDGE_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // Counts cycles the current bus cycle has been waiting for an acknowledge.
   assign tmo_hit = (tmo_cnt == TIMEOUT - 16'd1);

   // Timeout counter, restarted whenever no bus cycle is outstanding.
   always_ff @(posedge clk) begin
      if (reset || state != BUS || !wb_cyc_o) tmo_cnt <= 16'd0;
      else if (!wb_ack_i && !tmo_hit)         tmo_cnt <= tmo_cnt + 16'd1;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)        bus_err_o <= 1'b0;
      else if (bus_tmo) bus_err_o <= 1'b1;
   end
`else
   assign tmo_hit   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

endmodule
